// File: rtl/memory_stage.sv
// Pipeline memory stage: byte/half/word loads and stores over a valid/ready
// data-memory port, registering the result onto the write-back bundle.

package memory_stage_pkg;
   localparam int unsigned XLEN = 32;
   typedef logic [XLEN-1:0] data_t;
   typedef logic [1:0]      result_src_t;
   typedef logic [4:0]      reg_idx_t;
endpackage

interface mem_to_wb_if;
   import memory_stage_pkg::*;
   result_src_t cfsm__result_src;
   data_t       read_data;
   data_t       alu_result;
   reg_idx_t    rd;
   logic        RegWriteW;

   modport to_write_back (
      output cfsm__result_src, read_data, alu_result, rd, RegWriteW
   );
   modport from_memory (
      input cfsm__result_src, read_data, alu_result, rd, RegWriteW
   );
endinterface

module memory_stage
   import memory_stage_pkg::*;
#(
   parameter int unsigned BUS_W = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [BUS_W-1:0]   in_alu_result,
   input  logic [BUS_W-1:0]   in_write_data,
   input  logic               in_mem_read,
   input  logic               in_mem_write,
   input  logic [2:0]         in_funct3,
   input  logic [4:0]         in_rd,
   input  logic               in_reg_write,
   input  result_src_t        in_result_src,
   output logic               dmem_req_valid,
   input  logic               dmem_req_ready,
   output logic [BUS_W-1:0]   dmem_addr,
   output logic               dmem_we,
   output logic [3:0]         dmem_wstrb,
   output logic [BUS_W-1:0]   dmem_wdata,
   input  logic               dmem_resp_valid,
   input  logic [BUS_W-1:0]   dmem_rdata,
   output logic               mem_fault,
   mem_to_wb_if.to_write_back mem_to_wb
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]       state_q, state_d;

   // Captured instruction
   logic [BUS_W-1:0] addr_q, addr_d;
   logic [BUS_W-1:0] wdata_q, wdata_d;
   logic [2:0]       funct3_q, funct3_d;
   logic [4:0]       rd_q, rd_d;
   logic             reg_write_q, reg_write_d;
   result_src_t      src_q, src_d;
   logic             is_load_q, is_load_d;

   // Write-back registers
   result_src_t      wb_src_q, wb_src_d;
   logic [BUS_W-1:0] wb_rdata_q, wb_rdata_d;
   logic [BUS_W-1:0] wb_alu_q, wb_alu_d;
   logic [4:0]       wb_rd_q, wb_rd_d;
   logic             wb_we_q, wb_we_d;
   logic             fault_q, fault_d;

   logic [1:0]       off_in;
   logic             mem_op_in;
   logic             f3_legal;
   logic             misalign;
   logic             fault_in;

   logic [1:0]       off_q;
   logic             in_req;
   logic [3:0]       strb;
   logic [BUS_W-1:0] store_data;
   logic [7:0]       byte_sel;
   logic [15:0]      half_sel;
   logic [BUS_W-1:0] load_data;

   // Legality of the instruction presented at capture
   assign off_in    = in_alu_result[1:0];
   assign mem_op_in = in_mem_read | in_mem_write;

   always_comb begin
      f3_legal = 1'b0;
      case (in_funct3)
         3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
         3'b100, 3'b101:         f3_legal = in_mem_read;
         default:                f3_legal = 1'b0;
      endcase
   end

   assign misalign = ((in_funct3[1:0] == 2'b01) && off_in[0]) ||
                     ((in_funct3[1:0] == 2'b10) && (off_in != 2'b00));
   assign fault_in = (in_mem_read & in_mem_write) |
                     (mem_op_in & (~f3_legal | misalign));

   // Store lane encoding from the captured access
   assign off_q  = addr_q[1:0];
   assign in_req = (state_q == S_REQ);

   always_comb begin
      strb       = 4'b1111;
      store_data = wdata_q;
      case (funct3_q[1:0])
         2'b00: begin
            strb       = 4'b0001 << off_q;
            store_data = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            strb       = 4'b0011 << off_q;
            store_data = {2{wdata_q[15:0]}};
         end
         default: begin
            strb       = 4'b1111;
            store_data = wdata_q;
         end
      endcase
   end

   assign dmem_req_valid = in_req;
   assign dmem_addr      = {addr_q[BUS_W-1:2], 2'b00};
   assign dmem_we        = in_req & ~is_load_q;
   assign dmem_wstrb     = (in_req && !is_load_q) ? strb : 4'b0000;
   assign dmem_wdata     = store_data;
   assign in_ready       = (state_q == S_IDLE);
   assign mem_fault      = fault_q;

   // Load lane extraction and extension
   assign byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
   assign half_sel = dmem_rdata[{off_q[1], 4'b0000} +: 16];

   always_comb begin
      load_data = dmem_rdata;
      case (funct3_q)
         3'b000:  load_data = {{(BUS_W-8){byte_sel[7]}}, byte_sel};
         3'b100:  load_data = {{(BUS_W-8){1'b0}}, byte_sel};
         3'b001:  load_data = {{(BUS_W-16){half_sel[15]}}, half_sel};
         3'b101:  load_data = {{(BUS_W-16){1'b0}}, half_sel};
         default: load_data = dmem_rdata;
      endcase
   end

   // Next state; every non-completion cycle issues a write-back bubble
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      funct3_d    = funct3_q;
      rd_d        = rd_q;
      reg_write_d = reg_write_q;
      src_d       = src_q;
      is_load_d   = is_load_q;
      wb_src_d    = wb_src_q;
      wb_rdata_d  = wb_rdata_q;
      wb_alu_d    = wb_alu_q;
      wb_rd_d     = wb_rd_q;
      wb_we_d     = 1'b0;
      fault_d     = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               addr_d      = in_alu_result;
               wdata_d     = in_write_data;
               funct3_d    = in_funct3;
               rd_d        = in_rd;
               reg_write_d = in_reg_write;
               src_d       = in_result_src;
               is_load_d   = in_mem_read;
               if (!mem_op_in || fault_in) begin
                  wb_src_d   = in_result_src;
                  wb_alu_d   = in_alu_result;
                  wb_rd_d    = in_rd;
                  wb_rdata_d = '0;
                  wb_we_d    = in_reg_write & ~fault_in;
                  fault_d    = fault_in;
               end else begin
                  state_d = S_REQ;
               end
            end
         end
         S_REQ: begin
            if (dmem_req_ready) begin
               if (is_load_q) begin
                  state_d = S_WAIT;
               end else begin
                  wb_src_d   = src_q;
                  wb_alu_d   = addr_q;
                  wb_rd_d    = rd_q;
                  wb_rdata_d = '0;
                  wb_we_d    = reg_write_q;
                  state_d    = S_IDLE;
               end
            end
         end
         S_WAIT: begin
            if (dmem_resp_valid) begin
               wb_src_d   = src_q;
               wb_alu_d   = addr_q;
               wb_rd_d    = rd_q;
               wb_rdata_d = load_data;
               wb_we_d    = reg_write_q;
               state_d    = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         funct3_q    <= '0;
         rd_q        <= '0;
         reg_write_q <= 1'b0;
         src_q       <= '0;
         is_load_q   <= 1'b0;
         wb_src_q    <= '0;
         wb_rdata_q  <= '0;
         wb_alu_q    <= '0;
         wb_rd_q     <= '0;
         wb_we_q     <= 1'b0;
         fault_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         funct3_q    <= funct3_d;
         rd_q        <= rd_d;
         reg_write_q <= reg_write_d;
         src_q       <= src_d;
         is_load_q   <= is_load_d;
         wb_src_q    <= wb_src_d;
         wb_rdata_q  <= wb_rdata_d;
         wb_alu_q    <= wb_alu_d;
         wb_rd_q     <= wb_rd_d;
         wb_we_q     <= wb_we_d;
         fault_q     <= fault_d;
      end
   end

   assign mem_to_wb.cfsm__result_src = wb_src_q;
   assign mem_to_wb.read_data        = wb_rdata_q;
   assign mem_to_wb.alu_result       = wb_alu_q;
   assign mem_to_wb.rd               = wb_rd_q;
   assign mem_to_wb.RegWriteW        = wb_we_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: ALU pass-through, loads, stores with
// back-pressure, faults and reset during an outstanding load.

module tb_memory_stage;

   logic        clk;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_alu_result;
   logic [31:0] in_write_data;
   logic        in_mem_read;
   logic        in_mem_write;
   logic [2:0]  in_funct3;
   logic [4:0]  in_rd;
   logic        in_reg_write;
   logic [1:0]  in_result_src;
   logic        dmem_req_valid;
   logic        dmem_req_ready;
   logic [31:0] dmem_addr;
   logic        dmem_we;
   logic [3:0]  dmem_wstrb;
   logic [31:0] dmem_wdata;
   logic        dmem_resp_valid;
   logic [31:0] dmem_rdata;
   logic        mem_fault;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;

   mem_to_wb_if wb_if ();

   memory_stage #(.BUS_W(32)) dut (
      .clk             (clk),
      .reset           (reset),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_alu_result   (in_alu_result),
      .in_write_data   (in_write_data),
      .in_mem_read     (in_mem_read),
      .in_mem_write    (in_mem_write),
      .in_funct3       (in_funct3),
      .in_rd           (in_rd),
      .in_reg_write    (in_reg_write),
      .in_result_src   (in_result_src),
      .dmem_req_valid  (dmem_req_valid),
      .dmem_req_ready  (dmem_req_ready),
      .dmem_addr       (dmem_addr),
      .dmem_we         (dmem_we),
      .dmem_wstrb      (dmem_wstrb),
      .dmem_wdata      (dmem_wdata),
      .dmem_resp_valid (dmem_resp_valid),
      .dmem_rdata      (dmem_rdata),
      .mem_fault       (mem_fault),
      .mem_to_wb       (wb_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      in_valid      = 1'b0;
      in_mem_read   = 1'b0;
      in_mem_write  = 1'b0;
      in_funct3     = 3'b000;
      in_reg_write  = 1'b0;
   endtask

   task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                          input logic [31:0] word, input logic [31:0] exp);
      logic [31:0] waddr;
      waddr          = {addr[31:2], 2'b00};
      in_valid       = 1'b1;
      in_mem_read    = 1'b1;
      in_mem_write   = 1'b0;
      in_funct3      = f3;
      in_alu_result  = addr;
      in_rd          = 5'd7;
      in_reg_write   = 1'b1;
      in_result_src  = 2'b10;
      dmem_req_ready = 1'b1;
      tick();
      idle_inputs();
      chk({tag, "_req_valid"}, dmem_req_valid, 32'd1);
      chk({tag, "_addr"}, dmem_addr, waddr);
      chk({tag, "_we"}, dmem_we, 32'd0);
      chk({tag, "_in_ready_req"}, in_ready, 32'd0);
      tick();
      chk({tag, "_req_done"}, dmem_req_valid, 32'd0);
      chk({tag, "_in_ready_wait"}, in_ready, 32'd0);
      chk({tag, "_bubble"}, wb_if.RegWriteW, 32'd0);
      dmem_resp_valid = 1'b1;
      dmem_rdata      = word;
      tick();
      dmem_resp_valid = 1'b0;
      dmem_req_ready  = 1'b0;
      chk({tag, "_regwrite"}, wb_if.RegWriteW, 32'd1);
      chk({tag, "_rdata"}, wb_if.read_data, exp);
      chk({tag, "_rd"}, wb_if.rd, 32'd7);
      chk({tag, "_alu"}, wb_if.alu_result, addr);
      chk({tag, "_src"}, wb_if.cfsm__result_src, 32'd2);
      chk({tag, "_in_ready_done"}, in_ready, 32'd1);
   endtask

   task automatic do_fault(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic rd_en, input logic wr_en);
      in_valid      = 1'b1;
      in_mem_read   = rd_en;
      in_mem_write  = wr_en;
      in_funct3     = f3;
      in_alu_result = addr;
      in_rd         = 5'd9;
      in_reg_write  = 1'b1;
      tick();
      idle_inputs();
      chk({tag, "_fault"}, mem_fault, 32'd1);
      chk({tag, "_no_req"}, dmem_req_valid, 32'd0);
      chk({tag, "_regwrite"}, wb_if.RegWriteW, 32'd0);
      chk({tag, "_in_ready"}, in_ready, 32'd1);
      chk({tag, "_alu"}, wb_if.alu_result, addr);
      tick();
      chk({tag, "_fault_pulse"}, mem_fault, 32'd0);
      chk({tag, "_no_req2"}, dmem_req_valid, 32'd0);
   endtask

   task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rs2, input int unsigned stall,
                           input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
      in_valid       = 1'b1;
      in_mem_write   = 1'b1;
      in_mem_read    = 1'b0;
      in_funct3      = f3;
      in_alu_result  = addr;
      in_write_data  = rs2;
      in_rd          = 5'd0;
      in_reg_write   = 1'b0;
      in_result_src  = 2'b00;
      dmem_req_ready = 1'b0;
      tick();
      idle_inputs();
      for (int unsigned i = 0; i <= stall; i++) begin
         if (i == stall) dmem_req_ready = 1'b1;
         chk({tag, "_req_valid"}, dmem_req_valid, 32'd1);
         chk({tag, "_addr"}, dmem_addr, {addr[31:2], 2'b00});
         chk({tag, "_we"}, dmem_we, 32'd1);
         chk({tag, "_wstrb"}, dmem_wstrb, exp_strb);
         chk({tag, "_wdata"}, dmem_wdata, exp_wdata);
         chk({tag, "_in_ready"}, in_ready, 32'd0);
         tick();
      end
      dmem_req_ready = 1'b0;
      chk({tag, "_done_req"}, dmem_req_valid, 32'd0);
      chk({tag, "_done_wstrb"}, dmem_wstrb, 32'd0);
      chk({tag, "_done_ready"}, in_ready, 32'd1);
      chk({tag, "_done_regwrite"}, wb_if.RegWriteW, 32'd0);
      chk({tag, "_done_alu"}, wb_if.alu_result, addr);
   endtask

   initial begin
      reset           = 1'b0;
      idle_inputs();
      in_alu_result   = '0;
      in_write_data   = '0;
      in_rd           = '0;
      in_result_src   = '0;
      dmem_req_ready  = 1'b0;
      dmem_resp_valid = 1'b0;
      dmem_rdata      = '0;
      tick();
      tick();
      chk("rst_in_ready", in_ready, 32'd1);
      chk("rst_req_valid", dmem_req_valid, 32'd0);
      chk("rst_we", dmem_we, 32'd0);
      chk("rst_wstrb", dmem_wstrb, 32'd0);
      chk("rst_fault", mem_fault, 32'd0);
      chk("rst_wb_we", wb_if.RegWriteW, 32'd0);
      chk("rst_wb_rdata", wb_if.read_data, 32'd0);
      chk("rst_wb_alu", wb_if.alu_result, 32'd0);
      chk("rst_wb_rd", wb_if.rd, 32'd0);
      chk("rst_wb_src", wb_if.cfsm__result_src, 32'd0);
      reset = 1'b1;
      tick();

      // ALU pass-through
      in_valid      = 1'b1;
      in_alu_result = 32'h0000_1234;
      in_rd         = 5'd5;
      in_reg_write  = 1'b1;
      in_result_src = 2'b01;
      tick();
      idle_inputs();
      chk("alu_regwrite", wb_if.RegWriteW, 32'd1);
      chk("alu_rd", wb_if.rd, 32'd5);
      chk("alu_result", wb_if.alu_result, 32'h0000_1234);
      chk("alu_rdata", wb_if.read_data, 32'd0);
      chk("alu_src", wb_if.cfsm__result_src, 32'd1);
      chk("alu_no_req", dmem_req_valid, 32'd0);
      chk("alu_in_ready", in_ready, 32'd1);
      tick();
      chk("alu_bubble", wb_if.RegWriteW, 32'd0);
      chk("alu_rd_hold", wb_if.rd, 32'd5);

      // Loads
      do_load("lb",  32'h0000_1003, 3'b000, 32'h80FF_FF7F, 32'hFFFF_FF80);
      do_load("lbu", 32'h0000_1003, 3'b100, 32'h80FF_FF7F, 32'h0000_0080);
      do_load("lb0", 32'h0000_1000, 3'b000, 32'h80FF_FF7F, 32'h0000_007F);
      do_load("lh",  32'h0000_1002, 3'b001, 32'h80FF_FF7F, 32'hFFFF_80FF);
      do_load("lhu", 32'h0000_1000, 3'b101, 32'h80FF_FF7F, 32'h0000_FF7F);
      do_load("lw",  32'h0000_1004, 3'b010, 32'h80FF_FF7F, 32'h80FF_FF7F);

      // Stores
      do_store("sh", 32'h0000_2002, 3'b001, 32'hAAAA_BEEF, 4, 4'b1100, 32'hBEEF_BEEF);
      do_store("sb", 32'h0000_2001, 3'b000, 32'h1234_5678, 0, 4'b0010, 32'h7878_7878);
      do_store("sw", 32'h0000_2004, 3'b010, 32'hCAFE_F00D, 1, 4'b1111, 32'hCAFE_F00D);

      // Faults
      do_fault("lw_mis",  32'h0000_3001, 3'b010, 1'b1, 1'b0);
      do_fault("lh_mis",  32'h0000_3001, 3'b001, 1'b1, 1'b0);
      do_fault("f3_bad",  32'h0000_3000, 3'b011, 1'b1, 1'b0);
      do_fault("rw_both", 32'h0000_3000, 3'b010, 1'b1, 1'b1);

      // Reset while waiting for a load response
      in_valid       = 1'b1;
      in_mem_read    = 1'b1;
      in_funct3      = 3'b010;
      in_alu_result  = 32'h0000_4000;
      in_rd          = 5'd11;
      in_reg_write   = 1'b1;
      dmem_req_ready = 1'b1;
      tick();
      idle_inputs();
      tick();
      dmem_req_ready = 1'b0;
      chk("rstw_in_wait", in_ready, 32'd0);
      reset = 1'b0;
      #2;
      chk("rstw_in_ready", in_ready, 32'd1);
      chk("rstw_req_valid", dmem_req_valid, 32'd0);
      chk("rstw_wb_alu", wb_if.alu_result, 32'd0);
      chk("rstw_wb_rd", wb_if.rd, 32'd0);
      chk("rstw_wb_rdata", wb_if.read_data, 32'd0);
      tick();
      reset = 1'b1;
      dmem_resp_valid = 1'b1;
      dmem_rdata      = 32'hDEAD_BEEF;
      tick();
      dmem_resp_valid = 1'b0;
      chk("late_resp_regwrite", wb_if.RegWriteW, 32'd0);
      chk("late_resp_rdata", wb_if.read_data, 32'd0);
      chk("late_resp_in_ready", in_ready, 32'd1);
      chk("late_resp_req", dmem_req_valid, 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
